// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, serialised LSB-first as
// start(0) + DATA_BITS + STOP_BITS stop(1), each bit OVERSAMPLE clock_enable ticks long.
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic                 clock_enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]           state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 tick_last;
  logic                 period_end;

  // The shift register always presents the current bit at [0]; bit_idx only
  // tracks how many have gone out.
  assign shift_nxt  = shift >> 1;
  assign tick_last  = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign period_end = clock_enable && tick_last;

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tick_cnt <= '0;
    end else begin
      if (state != S_IDLE && clock_enable)
        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (valid && ready) begin
            shift    <= data;
            state    <= S_START;
            tx       <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
            tick_cnt <= '0;
          end
        end
        S_START: begin
          if (period_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        S_DATA: begin
          if (period_end) begin
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              state    <= S_STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift_nxt;
              tx      <= shift_nxt[0];
            end
          end
        end
        default: begin
          if (period_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state <= S_IDLE;
              ready <= 1'b1;
              busy  <= 1'b0;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a line-decoding monitor checks each frame against a
// queue of expected bytes; the stimulus thread checks reset, exact waveforms and timing.
module tb_uart_transmitter;

  logic       CLKIN = 1'b0;
  logic       RESET = 1'b0;
  logic       clock_enable = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b1;
  int         bit_clks = 16;
  int         ce_div = 1;
  int         ce_cnt = 0;

  uart_transmitter #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut (
    .CLKIN(CLKIN), .RESET(RESET), .clock_enable(clock_enable),
    .data(data), .valid(valid), .ready(ready), .tx(tx), .busy(busy)
  );

  initial forever #5 CLKIN = ~CLKIN;

  initial forever begin
    @(posedge CLKIN);
    #1;
    ce_cnt = (ce_cnt + 1) % ce_div;
    clock_enable = (ce_cnt == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int t = 0;
    while (ready !== 1'b1 && t < 2000) begin
      @(negedge CLKIN);
      t++;
    end
    chk(nm, 32'(ready), 1);
  endtask

  // Sends one byte with clock_enable high and checks tx on every clock of the frame.
  task automatic wave_check(input logic [7:0] b, input string nm);
    int   errs = 0;
    int   first = -1;
    logic e;
    wait_ready({nm, "_ready_before"});
    @(negedge CLKIN);
    data  = b;
    valid = 1'b1;
    exp_q.push_back(b);
    @(posedge CLKIN);
    #1 valid = 1'b0;
    for (int k = 0; k < 160; k++) begin
      @(negedge CLKIN);
      if (k < 16)       e = 1'b0;
      else if (k < 144) e = b[k/16 - 1];
      else              e = 1'b1;
      if (tx !== e) begin
        errs++;
        if (first < 0) first = k;
      end
      if (k == 159) chk({nm, "_ready_low_at_159"}, 32'(ready), 0);
    end
    chk({nm, "_wave_errs"}, errs, 0);
    if (first >= 0) $display("  first wave error of %s at clock %0d", nm, first);
    @(negedge CLKIN);
    chk({nm, "_ready_at_160"}, 32'(ready), 1);
    chk({nm, "_busy_at_160"}, 32'(busy), 0);
  endtask

  // Monitor: decodes frames off tx by mid-bit sampling and scores them.
  initial begin : monitor
    logic [7:0] got;
    logic       st, sp;
    forever begin
      @(negedge CLKIN);
      if (mon_en && tx === 1'b0) begin
        repeat (bit_clks/2 - 1) @(negedge CLKIN);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (bit_clks) @(negedge CLKIN);
          got[i] = tx;
        end
        repeat (bit_clks) @(negedge CLKIN);
        sp = tx;
        chk("mon_start_bit", 32'(st), 0);
        chk("mon_stop_bit", 32'(sp), 1);
        chk("mon_frame_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("mon_data", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin : stim
    int len;
    // Reset is asynchronous: outputs settle before any clock edge.
    #1 RESET = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    #20 RESET = 1'b0;
    repeat (2) @(negedge CLKIN);
    chk("rst_hold_tx", 32'(tx), 1);
    chk("rst_hold_ready", 32'(ready), 1);
    chk("rst_hold_busy", 32'(busy), 0);

    wave_check(8'hA5, "a5");

    // Divided tick, acceptance aligned to a clock_enable edge: 64 clocks per bit.
    repeat (4) @(negedge CLKIN);
    ce_div   = 4;
    bit_clks = 64;
    repeat (8) @(negedge CLKIN);
    wait_ready("div_ready_before");
    while (clock_enable !== 1'b1) @(negedge CLKIN);
    data  = 8'h3C;
    valid = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge CLKIN);
    #1 valid = 1'b0;
    len = 0;
    @(negedge CLKIN);
    while (busy === 1'b1 && len < 2000) begin
      len++;
      @(negedge CLKIN);
    end
    chk("div_busy_len", len, 640);
    repeat (4) @(negedge CLKIN);
    ce_div   = 1;
    bit_clks = 16;
    repeat (4) @(negedge CLKIN);

    // Back-to-back with valid held; data wiggles during frame 1.
    wait_ready("b2b_ready_before");
    @(negedge CLKIN);
    data  = 8'h00;
    valid = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    @(posedge CLKIN);
    #1;
    for (int k = 0; k < 162; k++) begin
      @(negedge CLKIN);
      if (k == 20)  data = 8'h77;
      if (k == 150) data = 8'hFF;
      if (k == 159) chk("b2b_stop_high", 32'(tx), 1);
      if (k == 160) begin
        chk("b2b_gap_tx", 32'(tx), 1);
        chk("b2b_gap_ready", 32'(ready), 1);
      end
      if (k == 161) begin
        chk("b2b_second_start", 32'(tx), 0);
        chk("b2b_second_busy", 32'(busy), 1);
        valid = 1'b0;
      end
    end
    wait_ready("b2b_ready_after");
    repeat (4) @(negedge CLKIN);

    // Abort 0x55 during data bit 3, then a clean 0x0F.
    mon_en = 1'b0;
    @(negedge CLKIN);
    data  = 8'h55;
    valid = 1'b1;
    @(posedge CLKIN);
    #1 valid = 1'b0;
    repeat (70) @(negedge CLKIN);
    chk("abort_bit3_low", 32'(tx), 0);
    #2 RESET = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 1);
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) @(posedge CLKIN);
    #2 RESET = 1'b0;
    @(negedge CLKIN);
    chk("abort_hold_tx", 32'(tx), 1);
    mon_en = 1'b1;
    wave_check(8'h0F, "0f");

    repeat (10) @(negedge CLKIN);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
